// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        WAIT  = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam logic [1:0] FILL_LAST = 2'd3;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// rtl/pipeline_hazard_ctrl_hazard_cmp.sv - RAW compare of the ID sources against one writer stage
module hazard_cmp
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       wr_en,
    input  logic [4:0] dest,
    output logic       hit
);

    // Register 0 is hardwired, so a write to it can never feed a reader.
    assign hit = wr_en && (dest != REG_ZERO) &&
                 ((dest == id_rs) || (id_uses_rt && (dest == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stage-enable sequencer for the five-stage core; HAZARD_STATS_EN adds counters
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_reg_wr,
    input  logic [4:0]       ex_dest,
    input  logic             mem_reg_wr,
    input  logic [4:0]       mem_dest,
    input  logic             mem_busy,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] wait_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pc_jump_sel
);

    hz_state_t  state_q, state_d;
    logic [1:0] fill_cnt_q, fill_cnt_d;
    logic       ex_hit, mem_hit, hz;
    logic       take_wait, take_stall, take_jump;

    hazard_cmp u_cmp_ex (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .wr_en      (ex_reg_wr),
        .dest       (ex_dest),
        .hit        (ex_hit)
    );

    hazard_cmp u_cmp_mem (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .wr_en      (mem_reg_wr),
        .dest       (mem_dest),
        .hit        (mem_hit)
    );

    // WB writers are deliberately absent: the register bank writes before it reads.
    assign hz = ex_hit || mem_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            fill_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        pc_jump_sel   = 1'b0;
        take_wait     = 1'b0;
        take_stall    = 1'b0;
        take_jump     = 1'b0;

        if (state_q == FILL) begin
            pc_enable     = 1'b1;
            if_id_enable  = 1'b1;
            id_ex_enable  = (fill_cnt_q >= 2'd1);
            ex_mem_enable = (fill_cnt_q >= 2'd2);
            mem_wb_enable = (fill_cnt_q >= 2'd3);
            fill_cnt_d    = fill_cnt_q + 2'd1;
            if (fill_cnt_q == FILL_LAST) begin
                state_d = RUN;
            end
        end else if (mem_busy) begin
            take_wait = 1'b1;
            state_d   = WAIT;
        end else if (hz) begin
            take_stall    = 1'b1;
            id_ex_enable  = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
            state_d       = STALL;
        end else begin
            take_jump     = id_jump;
            pc_enable     = 1'b1;
            if_id_enable  = 1'b1;
            id_ex_enable  = 1'b1;
            ex_mem_enable = 1'b1;
            mem_wb_enable = 1'b1;
            pc_jump_sel   = id_jump;
            if_id_flush   = id_jump;
            state_d       = RUN;
        end

        // Hold the whole pipeline quiet while reset is asserted.
        if (rst) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_bubble  = 1'b0;
            pc_jump_sel   = 1'b0;
            take_wait     = 1'b0;
            take_stall    = 1'b0;
            take_jump     = 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            wait_cycles  <= '0;
            flush_count  <= '0;
        end else begin
            if (take_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_ONE;
            if (take_wait  && (wait_cycles  != '1)) wait_cycles  <= wait_cycles  + CNT_ONE;
            if (take_jump  && (flush_count  != '1)) flush_count  <= flush_count  + CNT_ONE;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = take_wait ^ take_stall ^ take_jump;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven check of the pipeline hazard controller
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    // exp bits: pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble, jump_sel
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       ex_wr;
        logic [4:0] ex_dest;
        logic       mem_wr;
        logic [4:0] mem_dest;
        logic       busy;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0, mem_dest = '0;
    logic       id_uses_rt = 1'b0, id_jump = 1'b0, ex_reg_wr = 1'b0, mem_reg_wr = 1'b0, mem_busy = 1'b0;
    logic       pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
    logic       if_id_flush, id_ex_bubble, pc_jump_sel;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cycles, wait_cycles, flush_count;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs [20];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .id_jump       (id_jump),
        .ex_reg_wr     (ex_reg_wr),
        .ex_dest       (ex_dest),
        .mem_reg_wr    (mem_reg_wr),
        .mem_dest      (mem_dest),
        .mem_busy      (mem_busy),
`ifdef HAZARD_STATS_EN
        .stall_cycles  (stall_cycles),
        .wait_cycles   (wait_cycles),
        .flush_count   (flush_count),
`endif
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .id_ex_enable  (id_ex_enable),
        .ex_mem_enable (ex_mem_enable),
        .mem_wb_enable (mem_wb_enable),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .pc_jump_sel   (pc_jump_sel)
    );

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic jump, input logic ex_wr, input logic [4:0] exd,
                                input logic mem_wr, input logic [4:0] memd, input logic busy,
                                input logic [7:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.jump = jump; v.ex_wr = ex_wr;
        v.ex_dest = exd; v.mem_wr = mem_wr; v.mem_dest = memd; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                if_id_flush, id_ex_bubble, pc_jump_sel};
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_jump = v.jump;
        ex_reg_wr = v.ex_wr; ex_dest = v.ex_dest; mem_reg_wr = v.mem_wr;
        mem_dest = v.mem_dest; mem_busy = v.busy;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
    task automatic run_vec(input int idx);
        @(negedge clk);
        apply(vecs[idx]);
        #1;
        check8($sformatf("vec%0d", idx), outs(), vecs[idx].exp);
    endtask

    initial begin
        //               rs     rt     urt   jmp   exwr  exd    memwr memd   busy  expected
        vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11000_000);
        vecs[1]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 8'b11100_000);
        vecs[2]  = mk(5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 8'b11110_000);
        vecs[3]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[4]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[5]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 8'b00111_010);
        vecs[6]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 8'b00111_010);
        vecs[7]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[9]  = mk(5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[10] = mk(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 8'b00111_010);
        vecs[11] = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_101);
        vecs[12] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[13] = mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 8'b00000_000);
        vecs[14] = mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 8'b00000_000);
        vecs[15] = mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 8'b00000_000);
        vecs[16] = mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 8'b00111_010);
        vecs[17] = mk(5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_101);
        vecs[18] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 8'b11111_000);
        vecs[19] = mk(5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 8'b11111_000);

        @(negedge clk);
        #1;
        check8("reset_outputs", outs(), 8'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                apply(vecs[0]);
                #1;
                check8("vec0", outs(), vecs[0].exp);
            end else begin
                run_vec(i);
            end
        end

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        check_cnt("stall_cycles", int'(stall_cycles), 4);
        check_cnt("wait_cycles", int'(wait_cycles), 3);
        check_cnt("flush_count", int'(flush_count), 2);
`endif

        // Enter STALL, then pulse reset: outputs must drop at once, then FILL repeats.
        run_vec(5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check8("rst_in_stall", outs(), 8'b0);
        @(negedge clk);
        rst = 1'b0;
        apply(vecs[0]);
        #1;
        check8("refill0", outs(), vecs[0].exp);
        for (int i = 1; i < 5; i++) begin
            run_vec(i);
        end

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        check_cnt("stall_after_rst", int'(stall_cycles), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

- Sequences the stage-register enables of the five-stage core: PC register, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Sits beside the control unit in the core top and drives all five enables.
- After reset, releases the pipeline one stage per cycle.
- Detects read-after-write hazards between ID and EX/MEM and stalls with a bubble. The core has no forwarding.
- Squashes the slot fetched behind a jump and freezes the whole pipeline while data memory is busy.

## Interface
Parameters:
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (R-type, store, branch).
- id_jump  in  1  the ID instruction is a jump.
- ex_reg_wr  in  1  the EX instruction writes the register bank.
- ex_dest  in  5  EX destination, after the rd/rt mux.
- mem_reg_wr  in  1  the MEM instruction writes the register bank.
- mem_dest  in  5  MEM destination.
- mem_busy  in  1  data memory not ready; the access must be held.
- pc_enable  out  1  PC register load.
- if_id_enable  out  1  IF_ID load.
- id_ex_enable  out  1  ID_EX load.
- ex_mem_enable  out  1  EX_MEM load.
- mem_wb_enable  out  1  MEM_WB load.
- if_id_flush  out  1  IF_ID loads an all-zero NOP instead of the fetched word.
- id_ex_bubble  out  1  ID_EX loads with all control flags cleared.
- pc_jump_sel  out  1  PC mux select: 1 = jump address.
- stall_cycles  out  CNT_W  hazard-stall cycle count. Present only with the statistics macro.
- wait_cycles  out  CNT_W  memory-wait cycle count. Present only with the statistics macro.
- flush_count  out  CNT_W  jump flush count. Present only with the statistics macro.

## Operation
States: FILL, RUN, STALL, WAIT. State and fill_cnt (2 bits) are registered. All outputs are combinational decodes of the current state and current inputs.

Hazard term:
- hz = (ex_reg_wr & ex_dest≠0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt))), ORed with the same expression on mem_reg_wr/mem_dest.
- Register 0 never creates a hazard.
- A write in the WB stage is not a hazard. The register bank resolves same-cycle writes before reads.

FILL:
- pc_enable = 1 and if_id_enable = 1.
- id_ex_enable = (fill_cnt ≥ 1), ex_mem_enable = (fill_cnt ≥ 2), mem_wb_enable = (fill_cnt ≥ 3).
- id_jump, hz and mem_busy are ignored.
- fill_cnt increments each cycle. At fill_cnt == 3 the next state is RUN.

RUN, STALL and WAIT share one evaluation, checked in this priority order:
1. mem_busy: all five enables are 0, no flush, no bubble. Next state WAIT.
2. hz: pc_enable = 0, if_id_enable = 0, id_ex_enable = 1 with id_ex_bubble = 1, ex_mem_enable = 1, mem_wb_enable = 1. Next state STALL.
3. id_jump: all enables are 1, pc_jump_sel = 1, if_id_flush = 1. Next state RUN.
4. Otherwise all enables are 1. Next state RUN.

Other rules:
- id_jump is acted on only when neither mem_busy nor hz is active. A jump held in ID during a stall takes effect on the first clear cycle.
- pc_jump_sel and if_id_flush are 0 in every case except item 3.

## Timing
- Reset values: state FILL, fill_cnt 0, counters 0.
- While rst is high, every output is 0.
- Release from reset: RUN is reached 4 cycles after rst deasserts.
- Decision latency is zero. A hazard or busy input affects the enables in the same cycle, before the edge.
- A load followed by a dependent instruction stalls 2 cycles: one while the producer is in EX, one while it is in MEM.
- mem_busy held for N cycles freezes the pipeline for exactly N cycles.
- rst asserted mid-operation forces FILL immediately and clears fill_cnt.

## Configuration
- HAZARD_STATS_EN defined:
  - The three counters and their ports exist.
  - stall_cycles increments on each cycle of priority item 2; wait_cycles on item 1; flush_count on item 3.
  - Counters saturate at 2^CNT_W−1 and clear only on rst.
- HAZARD_STATS_EN undefined: the counters and their ports are absent. Control behaviour is identical.

## Structure
- Shared package:
  - State enum with encoding FILL=0, RUN=1, STALL=2, WAIT=3.
  - Constant REG_ZERO = 5'd0.
  - Constant FILL_LAST = 2'd3.
- One sub-module, hazard_cmp: purely combinational comparison of the ID sources against one writer stage. It is instantiated twice, once for EX and once for MEM.

## Test plan
- Reset release, no other stimulus → enable pattern across cycles 0..3 is 11000, 11100, 11110, 11111. Cycle 4 is in RUN with all enables 1.
- id_rs=8, ex_reg_wr=1, ex_dest=8; next cycle the producer moves to MEM (mem_dest=8) → 2 cycles with pc_enable=0 and id_ex_bubble=1, then normal flow. stall_cycles=2.
- ex_dest=0 with ex_reg_wr=1 and id_rs=0 → no stall.
- id_jump=1 with no hazard → one cycle of pc_jump_sel=1 and if_id_flush=1. flush_count=1.
- mem_busy high for 3 cycles while id_jump=1 and a hazard are also present → 3 cycles with all enables 0. Then the hazard stall runs, then the jump. wait_cycles=3.
- rst pulsed while in STALL → outputs 0 immediately. The 4-cycle FILL sequence repeats after deassertion.
